// File: rtl/mod_reduce_pipe.sv
// mod_reduce_pipe: three-stage Barrett reducer producing r = a mod Q, or
// (Q - (a mod Q)) mod Q when neg is set. It uses a valid/ready stream with one
// operand per cycle and a sideband tag that travels with each operand.
module mod_reduce_pipe #(
  parameter int unsigned Q  = 3329,
  parameter int unsigned QW = 12,
  parameter int unsigned AW = 24,
  parameter int unsigned TW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] a_i,
  input  logic          neg_i,
  input  logic [TW-1:0] tag_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [QW-1:0] r_o,
  output logic [TW-1:0] tag_o,
  output logic          busy_o
);

  // Barrett constants. K = AW makes the quotient estimate at most one short
  // for every operand below 2^K, so a single conditional subtract is enough.
  localparam int unsigned     K   = AW;
  localparam longint unsigned M   = (64'd1 << K) / 64'(Q);
  localparam int unsigned     MW  = $clog2(M + 64'd1);
  localparam int unsigned     PW  = AW + MW;
  localparam int unsigned     XW  = AW + MW + QW;
  localparam logic [MW-1:0]   M_L = MW'(M);
  localparam logic [QW-1:0]   Q_L = QW'(Q);
  localparam logic [QW:0]     Q_X = (QW+1)'(Q);

  logic          adv_s;
  logic          v1_r, v2_r, v3_r;
  logic [AW-1:0] a1_r;
  logic          neg1_r, neg2_r;
  logic [TW-1:0] tag1_r, tag2_r;
  logic [PW-1:0] p1_r, p_s;
  logic [MW-1:0] q_s;
  logic [QW:0]   t_s, t2_r, u_s;
  logic [QW-1:0] r_s;

  // The whole pipe moves together. It stalls only when a finished result is not taken.
  assign adv_s       = !v3_r || out_ready_i;
  assign in_ready_o  = adv_s;
  assign out_valid_o = v3_r;
  assign busy_o      = v1_r || v2_r || v3_r;

  // Full-width product of the operand and the Barrett multiplier.
  assign p_s = PW'(a_i) * PW'(M_L);

  // Stage valid bits. Bubbles advance like data whenever the pipe moves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else if (adv_s) begin
      v1_r <= in_valid_i;
      v2_r <= v1_r;
      v3_r <= v2_r;
    end
  end

  // Stage 1: capture the operand, mode, tag and product on an input handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a1_r   <= {AW{1'b0}};
      neg1_r <= 1'b0;
      tag1_r <= {TW{1'b0}};
      p1_r   <= {PW{1'b0}};
    end else if (adv_s && in_valid_i) begin
      a1_r   <= a_i;
      neg1_r <= neg_i;
      tag1_r <= tag_i;
      p1_r   <= p_s;
    end
  end

  // Stage 2 datapath: quotient estimate and remainder in [0, 2Q).
  // The true remainder fits in QW+1 bits, so a truncated subtraction is exact.
  always_comb begin
    q_s = {MW{1'b0}};
    t_s = {(QW+1){1'b0}};
    q_s = MW'(p1_r >> K);
    t_s = (QW+1)'(XW'(a1_r) - XW'(q_s) * XW'(Q_L));
  end

  // Stage 2 register: the partial remainder with its mode and tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t2_r   <= {(QW+1){1'b0}};
      neg2_r <= 1'b0;
      tag2_r <= {TW{1'b0}};
    end else if (adv_s && v1_r) begin
      t2_r   <= t_s;
      neg2_r <= neg1_r;
      tag2_r <= tag1_r;
    end
  end

  // Stage 3 datapath: final conditional subtract, then an optional negation.
  // t == Q reduces to 0.
  always_comb begin
    u_s = t2_r;
    r_s = {QW{1'b0}};
    if (t2_r >= Q_X) begin
      u_s = t2_r - Q_X;
    end else begin
      u_s = t2_r;
    end
    if (neg2_r) begin
      if (u_s == {(QW+1){1'b0}}) begin
        r_s = {QW{1'b0}};
      end else begin
        r_s = QW'(Q_X - u_s);
      end
    end else begin
      r_s = QW'(u_s);
    end
  end

  // Stage 3 register: the result and its tag. Both are held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_o   <= {QW{1'b0}};
      tag_o <= {TW{1'b0}};
    end else if (adv_s && v2_r) begin
      r_o   <= r_s;
      tag_o <= tag2_r;
    end
  end

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// tb_mod_reduce_pipe: scoreboard bench for mod_reduce_pipe. It covers the
// default Kyber instance and a Q=7681 / AW=26 instance.
module tb_mod_reduce_pipe;

  typedef struct {
    logic [31:0] r;
    logic [7:0]  tag;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   stall_cnt = 0;
  bit   lat_chk = 1'b0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  // Kyber instance signals
  logic        in_valid, in_ready, neg, out_valid, out_ready, busy;
  logic [23:0] a;
  logic [7:0]  tag, tag_o;
  logic [11:0] r;
  logic        stall_prev = 1'b0;
  logic [11:0] stall_r = 12'd0;
  logic [7:0]  stall_tag = 8'd0;

  // Q=7681 instance signals
  logic        b_in_valid, b_in_ready, b_neg, b_out_valid, b_out_ready, b_busy;
  logic [25:0] b_a;
  logic [7:0]  b_tag, b_tag_o;
  logic [12:0] b_r;

  logic [23:0] dir_a [6] = '{24'd0, 24'd3328, 24'd3329, 24'd11082240, 24'd11082241, 24'd16777215};
  logic [31:0] dir_r [6] = '{32'd0, 32'd3328, 32'd0, 32'd3328, 32'd0, 32'd2384};
  logic [23:0] neg_a [5] = '{24'd0, 24'd1, 24'd3328, 24'd3329, 24'd16777215};
  logic [31:0] neg_r [5] = '{32'd0, 32'd3328, 32'd1, 32'd0, 32'd945};

  always #5 clk = ~clk;

  // cycle counter used for latency and throughput checks
  always @(posedge clk) cyc <= cyc + 1;

  mod_reduce_pipe dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .neg_i(neg), .tag_i(tag), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .r_o(r), .tag_o(tag_o), .busy_o(busy)
  );

  mod_reduce_pipe #(.Q(7681), .QW(13), .AW(26), .TW(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .a_i(b_a), .neg_i(b_neg), .tag_i(b_tag), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .r_o(b_r), .tag_o(b_tag_o), .busy_o(b_busy)
  );

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mod(input longint unsigned av, input bit nv, input longint unsigned q);
    longint unsigned m;
    m = av % q;
    if (nv && m != 64'd0) m = q - m;
    return 32'(m);
  endfunction

  // offer one operand to dut_a and push its expectation when accepted
  task automatic send_a(input logic [23:0] av, input logic nv, input logic [7:0] tv, input logic [31:0] er);
    bit done = 1'b0;
    in_valid = 1'b1; a = av; neg = nv; tag = tv;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      if (done) sb_a.push_back('{er, tv, cyc});
      @(posedge clk); #1;
    end
    if (!done) check_eq("a_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_b(input logic [25:0] av, input logic nv, input logic [7:0] tv);
    bit done = 1'b0;
    b_in_valid = 1'b1; b_a = av; b_neg = nv; b_tag = tv;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = b_in_ready;
      if (done) sb_b.push_back('{ref_mod(64'(av), nv, 64'd7681), tv, cyc});
      @(posedge clk); #1;
    end
    if (!done) check_eq("b_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input bit which_b);
    bit empty = 1'b0;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(negedge clk);
      empty = which_b ? (sb_b.size() == 0 && !b_busy) : (sb_a.size() == 0 && !busy);
    end
    check_eq(which_b ? "b_drain" : "a_drain", 32'(empty), 32'd1);
    @(posedge clk); #1;
  endtask

  // dut_a output monitor: scoreboard pop, latency and stall stability
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_a.size() == 0) begin
          check_eq("a_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb_a.pop_front();
          check_eq("a_r", 32'(r), e.r);
          check_eq("a_tag", 32'(tag_o), 32'(e.tag));
          if (lat_chk) check_eq("a_latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 1;
        check_eq("a_stall_in_ready", 32'(in_ready), 32'd0);
        if (stall_prev) begin
          check_eq("a_stall_r", 32'(r), 32'(stall_r));
          check_eq("a_stall_tag", 32'(tag_o), 32'(stall_tag));
        end
        stall_prev <= 1'b1;
        stall_r    <= r;
        stall_tag  <= tag_o;
      end else begin
        stall_prev <= 1'b0;
      end
    end
  end

  // dut_b output monitor: scoreboard pop and range check
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_out_valid && b_out_ready) begin
      if (sb_b.size() == 0) begin
        check_eq("b_unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb_b.pop_front();
        check_eq("b_r", 32'(b_r), e.r);
        check_eq("b_tag", 32'(b_tag_o), 32'(e.tag));
        check_eq("b_range", 32'(b_r < 13'd7681), 32'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, s0;
    logic [23:0] av;
    logic        nv;
    logic [25:0] bv;
    rst_n = 1'b0;
    in_valid = 1'b0; a = 24'd0; neg = 1'b0; tag = 8'd0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_a = 26'd0; b_neg = 1'b0; b_tag = 8'd0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_r", 32'(r), 32'd0);
    check_eq("rst_tag", 32'(tag_o), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    // directed values, neg = 0
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) send_a(dir_a[i], 1'b0, 8'(i), dir_r[i]);
    in_valid = 1'b0;
    drain(1'b0);

    // negate mode
    for (int i = 0; i < 5; i++) send_a(neg_a[i], 1'b1, 8'(16 + i), neg_r[i]);
    in_valid = 1'b0;
    drain(1'b0);

    // backpressure: 5-cycle stall once the first result is presented
    lat_chk = 1'b0;
    out_ready = 1'b0;
    s0 = stall_cnt;
    fork
      begin
        logic [23:0] fv;
        logic        fn;
        for (int i = 0; i < 10; i++) begin
          fv = 24'($urandom_range(0, 16777215));
          fn = 1'($urandom_range(0, 1));
          send_a(fv, fn, 8'(32 + i), ref_mod(64'(fv), fn, 64'd3329));
        end
        in_valid = 1'b0;
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin
          @(posedge clk); #1;
          w++;
        end
        check_eq("a_bp_wait_valid", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(1'b0);
    check_eq("a_stall_cycles", 32'(stall_cnt - s0), 32'd5);

    // full-rate streaming
    lat_chk = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      av = 24'($urandom_range(0, 16777215));
      nv = 1'($urandom_range(0, 1));
      send_a(av, nv, 8'(i), ref_mod(64'(av), nv, 64'd3329));
    end
    in_valid = 1'b0;
    check_eq("a_fullrate_cycles", 32'(cyc - t0), 32'd1000);
    drain(1'b0);

    // reset with three operands in flight
    for (int i = 0; i < 3; i++) send_a(24'(1000 + i), 1'b0, 8'(100 + i), 32'(1000 + i));
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_r", 32'(r), 32'd0);
    sb_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    send_a(24'd7000, 1'b0, 8'd200, 32'd342);
    in_valid = 1'b0;
    drain(1'b0);

    // parameter sweep: Q=7681, exhaustive [0, 2Q] then random
    for (int i = 0; i <= 2 * 7681; i++) send_b(26'(i), 1'b0, 8'(i));
    for (int i = 0; i < 10000; i++) begin
      bv = 26'($urandom_range(0, 67108863));
      send_b(bv, 1'($urandom_range(0, 1)), 8'(i));
    end
    b_in_valid = 1'b0;
    drain(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_reduce_pipe.md
Name: mod_reduce_pipe

Overview:
- Parametrised, fully pipelined modular reducer: out = a mod Q, optionally negated mod Q.
- Uses Barrett reduction with a valid/ready stream interface and accepts one operand per cycle.
- Successor to the single-shot 3329 divider. Serves NTT butterflies and pointwise multipliers, with a tag field carried through so callers can track coefficient index.
- Default configuration is the Kyber modulus 3329 with 24-bit products.

Parameters:
- Q, 3329: modulus. Must be odd, with 2^(QW-1) < Q < 2^QW.
- QW, 12: result width in bits.
- AW, 24: operand width in bits. Must satisfy AW <= 2*QW.
- TW, 8: width of the sideband tag passed through unchanged.
- Derived localparams, not overridable: K = AW, M = floor(2^K / Q). M = 5039 for the defaults.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  block can accept an operand this cycle.
- a_i  in  AW  unsigned operand.
- neg_i  in  1  mode: 0 = a mod Q; 1 = (Q - (a mod Q)) mod Q.
- tag_i  in  TW  sideband, returned with the result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- r_o  out  QW  result, always in [0, Q-1].
- tag_o  out  TW  tag of the operand that produced r_o.
- busy_o  out  1  high while any pipeline stage holds valid data.

Behaviour:
- Reset (rst_ni low, asynchronous): all stage valid bits clear. out_valid_o=0, r_o=0, tag_o=0, busy_o=0. Data registers are also cleared to 0; they never sample a_i during reset.
- Pipeline: 3 register stages. Global advance enable: adv = !out_valid_o || out_ready_i.
- in_ready_o = adv, combinational. An input handshake is in_valid_i && in_ready_o.
- When adv=0, every stage holds: valids, data, tags and mode all frozen.
- Stage 1 registers a, neg, tag and the product p = a*M. p width is AW + bits(M).
- Stage 2 computes q = p >> K, then t = a - q*Q, truncated to QW+1 bits. Guaranteed 0 <= t < 2Q.
- Stage 3:
  - Compute u = (t >= Q) ? t - Q : t. The comparison is >=, so t == Q yields 0.
  - If neg, r = (u == 0) ? 0 : Q - u; otherwise r = u.
  - Register r into r_o.
- Latency: a result appears 3 cycles after its input handshake, provided adv stays high. Throughput is 1 result per cycle.
- Order: results leave in input order. tag_o and neg are aligned with their operand.
- Bubbles: an invalid stage still advances when adv=1. Bubbles are not compressed while out_valid_o=0 and out_ready_i=0, because adv=1 whenever out_valid_o=0.
- Output stability: while out_valid_o=1 && out_ready_i=0, r_o and tag_o are held stable.
- busy_o = OR of the three stage valid bits.
- Simultaneous input and output handshake in the same cycle is legal and sustains full rate.
- Mid-stream reset: all in-flight operands are discarded. out_valid_o drops asynchronously and no partial result is emitted after reset release.
- Boundary operands:
  - a = 0 gives 0.
  - a = Q gives 0.
  - a = Q-1 gives Q-1.
  - a = 2^AW - 1 must reduce exactly (error-free Barrett for every a < 2^K).

Test Plan:
- Directed values, neg=0, out_ready_i=1: a = 0, 3328, 3329, 11082240, 11082241, 16777215 -> r = 0, 3328, 0, 3328, 0, 2384. Each appears exactly 3 cycles after acceptance, with tags 0..5 in order.
- Negate mode: a = 0, 1, 3328, 3329, 16777215 with neg=1 -> r = 0, 3328, 1, 0, 945.
- Backpressure: stream 10 operands and hold out_ready_i=0 for 5 cycles once out_valid_o rises. Required: in_ready_o=0 throughout the stall, r_o and tag_o stable, no loss or duplication, full order preserved after release.
- Full-rate streaming: 1000 random a_i and neg_i with in_valid_i=1 and out_ready_i=1. Required: one result per cycle, each matching the model (a mod Q, negated if neg).
- Reset mid-operation: assert rst_ni low with 3 operands in flight. Required: out_valid_o=0, busy_o=0 and r_o=0 immediately. After release, the first result is from the first post-reset operand.
- Parameter sweep: Q=7681, QW=13, AW=26; exhaustive a in [0, 2*Q] plus 10000 random values. Required: all results correct and within [0, Q-1].
